// File: rtl/fir_tdm_sequencer.sv
// -----------------------------------------------------------------------------
// fir_tdm_sequencer
//
// Time-multiplexed FIR filter controller built around one shared
// multiply-accumulate datapath. Each accepted input sample is written into a
// circular delay line. The filter then walks the coefficient/sample pairs
// through the MAC at one pair per clock and presents the full-precision sum
// on a valid/ready output. Coefficients can be reloaded at runtime, but only
// while the block is idle.
//
// Build option:
//   FIR_SYMMETRIC_EN  linear-phase mode. Coefficient k serves both tap k and
//                     tap TAPS-1-k, so the two samples are pre-added and the
//                     run phase takes TAPS/2 cycles. Only coefficient
//                     addresses below TAPS/2 are writable.
//
// Ports:
//   clk            clock, all logic on the rising edge
//   reset          asynchronous, active-high reset
//   s_data         signed input sample
//   s_valid        input sample valid
//   s_ready        block can accept a sample (idle)
//   m_data         signed filter result, ACC_WIDTH bits
//   m_valid        result valid, held until m_ready
//   m_ready        downstream accepts the result
//   coef_wr_en     coefficient write strobe
//   coef_wr_addr   coefficient index
//   coef_wr_data   signed coefficient value
//   coef_wr_ready  a coefficient write is accepted this cycle (idle)
//   busy           computing, or holding an unconsumed result
//
// State  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for a sample; coefficient writes accepted
// S_RUN  | one MAC per cycle, tap index r_k counts up
// S_OUT  | result held on m_data until the downstream handshake
// -----------------------------------------------------------------------------
module fir_tdm_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(TAPS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic signed [ACC_WIDTH-1:0]  m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  input  logic                         coef_wr_en,
  input  logic [$clog2(TAPS)-1:0]      coef_wr_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_wr_data,
  output logic                         coef_wr_ready,
  output logic                         busy
);

  localparam int AW = $clog2(TAPS);

`ifdef FIR_SYMMETRIC_EN
  localparam int NCOEF   = TAPS / 2;
  localparam int MUL_A_W = DATA_WIDTH + 1;
`else
  localparam int NCOEF   = TAPS;
  localparam int MUL_A_W = DATA_WIDTH;
`endif

  localparam int            CIW    = $clog2(NCOEF);
  localparam int            PROD_W = MUL_A_W + COEF_WIDTH;
  localparam logic [AW-1:0] LAST_K = AW'(NCOEF - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t                       r_state;
  logic                         r_s_ready;
  logic                         r_coef_wr_ready;
  logic                         r_busy;
  logic                         r_m_valid;
  logic signed [ACC_WIDTH-1:0]  r_m_data;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic [AW-1:0]                r_wr_ptr;
  logic [AW-1:0]                r_base;
  logic [AW-1:0]                r_k;
  logic signed [COEF_WIDTH-1:0] r_coef  [NCOEF];
  logic signed [DATA_WIDTH-1:0] r_delay [TAPS];

  // ---------------------------------------------------------------------------
  // Datapath wires
  // ---------------------------------------------------------------------------
  logic [AW-1:0]                w_tap_idx;
  logic signed [DATA_WIDTH-1:0] w_tap_sample;
  logic signed [MUL_A_W-1:0]    w_mul_a;
  logic signed [COEF_WIDTH-1:0] w_coef;
  logic signed [PROD_W-1:0]     w_product;
  logic signed [ACC_WIDTH-1:0]  w_product_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic                         w_coef_addr_ok;
  logic                         w_coef_wr;
  logic                         w_sample_acc;
  logic                         w_last_tap;
  logic                         w_out_hs;

  // Newest sample sits at r_base; older ones are found by walking backwards.
  // TAPS is a power of two, so the AW-bit subtraction wraps modulo TAPS.
  assign w_tap_idx    = r_base - r_k;
  assign w_tap_sample = r_delay[w_tap_idx];
  assign w_coef       = r_coef[r_k[CIW-1:0]];

`ifdef FIR_SYMMETRIC_EN
  logic [AW-1:0]                w_mirror_idx;
  logic signed [DATA_WIDTH-1:0] w_mirror_sample;

  // For power-of-two TAPS the partner tap TAPS-1-k is simply ~k.
  assign w_mirror_idx    = r_base - ~r_k;
  assign w_mirror_sample = r_delay[w_mirror_idx];

  // One guard bit keeps the pre-add exact.
  assign w_mul_a = {w_tap_sample[DATA_WIDTH-1], w_tap_sample}
                 + {w_mirror_sample[DATA_WIDTH-1], w_mirror_sample};

  // Upper half of the coefficient space does not exist in this mode.
  assign w_coef_addr_ok = ~coef_wr_addr[AW-1];
`else
  assign w_mul_a        = w_tap_sample;
  assign w_coef_addr_ok = 1'b1;
`endif

  assign w_product     = w_mul_a * w_coef;
  assign w_product_ext = {{(ACC_WIDTH-PROD_W){w_product[PROD_W-1]}}, w_product};
  assign w_acc_next    = r_acc + w_product_ext;

  assign w_coef_wr    = coef_wr_en && r_coef_wr_ready && w_coef_addr_ok;
  assign w_sample_acc = s_valid && r_s_ready;
  assign w_last_tap   = (r_k == LAST_K);
  assign w_out_hs     = r_m_valid && m_ready;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign s_ready       = r_s_ready;
  assign coef_wr_ready = r_coef_wr_ready;
  assign busy          = r_busy;
  assign m_valid       = r_m_valid;
  assign m_data        = r_m_data;

  // ---------------------------------------------------------------------------
  // Coefficient store. A write landing on the same edge as a sample accept
  // is visible to that computation because the first MAC reads one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCOEF; i++) begin
        r_coef[i] <= '0;
      end
    end else if (w_coef_wr) begin
      r_coef[coef_wr_addr[CIW-1:0]] <= coef_wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line. Cleared on reset so a cold start gives the zero-padded result.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        r_delay[i] <= '0;
      end
    end else if (w_sample_acc) begin
      r_delay[r_wr_ptr] <= s_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered handshake/status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_s_ready       <= 1'b1;
      r_coef_wr_ready <= 1'b1;
      r_busy          <= 1'b0;
      r_m_valid       <= 1'b0;
      r_m_data        <= '0;
      r_acc           <= '0;
      r_wr_ptr        <= '0;
      r_base          <= '0;
      r_k             <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_sample_acc) begin
            r_base          <= r_wr_ptr;
            r_acc           <= '0;
            r_k             <= '0;
            r_state         <= S_RUN;
            r_s_ready       <= 1'b0;
            r_coef_wr_ready <= 1'b0;
            r_busy          <= 1'b1;
          end
        end

        S_RUN: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + 1'b1;
          if (w_last_tap) begin
            // The final product bypasses r_acc so the result leaves this edge.
            r_m_data  <= w_acc_next;
            r_m_valid <= 1'b1;
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_state   <= S_OUT;
          end
        end

        S_OUT: begin
          if (w_out_hs) begin
            r_m_valid       <= 1'b0;
            r_state         <= S_IDLE;
            r_s_ready       <= 1'b1;
            r_coef_wr_ready <= 1'b1;
            r_busy          <= 1'b0;
          end
        end

        default: begin
          r_state         <= S_IDLE;
          r_s_ready       <= 1'b1;
          r_coef_wr_ready <= 1'b1;
          r_busy          <= 1'b0;
          r_m_valid       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tdm_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for fir_tdm_sequencer (default parameters, either build of
// FIR_SYMMETRIC_EN). The reference model is a plain convolution over a sample
// history array; expected values never come from the DUT.
// Latency is measured as the number of edges from the sample-accept edge to
// the output-handshake edge with m_ready held high.
// -----------------------------------------------------------------------------
module tb_fir_tdm_sequencer;

  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int TAPS = 16;
  localparam int AW   = 4;
  localparam int ACCW = 36;

`ifdef FIR_SYMMETRIC_EN
  localparam int RUN_CYC = TAPS / 2;
  localparam bit SYM     = 1'b1;
`else
  localparam int RUN_CYC = TAPS;
  localparam bit SYM     = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic signed [DW-1:0]   s_data;
  logic                   s_valid;
  logic                   s_ready;
  logic signed [ACCW-1:0] m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   coef_wr_en;
  logic [AW-1:0]          coef_wr_addr;
  logic signed [CW-1:0]   coef_wr_data;
  logic                   coef_wr_ready;
  logic                   busy;

  fir_tdm_sequencer #(
    .DATA_WIDTH(DW),
    .COEF_WIDTH(CW),
    .TAPS      (TAPS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_wr_ready(coef_wr_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  int acc_cyc  = 0;

  // ---------------------------------------------------------------------------
  // Reference model: coefficient table and history (index 0 = newest sample)
  // ---------------------------------------------------------------------------
  longint mc [TAPS];
  longint mh [TAPS];

  function automatic void model_reset();
    for (int i = 0; i < TAPS; i++) begin
      mc[i] = 0;
      mh[i] = 0;
    end
  endfunction

  function automatic void model_write(input int a, input longint d);
    if (!SYM || a < TAPS / 2) mc[a] = d;
  endfunction

  function automatic void model_push(input longint x);
    for (int i = TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
    mh[0] = x;
  endfunction

  function automatic longint model_out();
    longint s = 0;
    for (int j = 0; j < TAPS; j++) begin
      int c = (SYM && j >= TAPS / 2) ? (TAPS - 1 - j) : j;
      s += mc[c] * mh[j];
    end
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Check helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: no response within 200 cycles (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    reset      = 1'b1;
    s_valid    = 1'b0;
    coef_wr_en = 1'b0;
    m_ready    = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic write_coef(input int a, input logic signed [CW-1:0] d);
    check1("coef_wr_ready_idle", coef_wr_ready, 1'b1);
    coef_wr_en   = 1'b1;
    coef_wr_addr = a[AW-1:0];
    coef_wr_data = d;
    @(posedge clk); #1;
    coef_wr_en = 1'b0;
    model_write(a, longint'(d));
  endtask

  task automatic send(input logic signed [DW-1:0] x, input bit cw, input int ca,
                      input logic signed [CW-1:0] cd, output longint exp);
    int n = 0;
    s_data       = x;
    s_valid      = 1'b1;
    coef_wr_en   = cw;
    coef_wr_addr = ca[AW-1:0];
    coef_wr_data = cd;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      timeout("s_ready_wait");
      s_valid    = 1'b0;
      coef_wr_en = 1'b0;
      exp        = 0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc    = cyc;
    s_valid    = 1'b0;
    coef_wr_en = 1'b0;
    if (cw) model_write(ca, longint'(cd));
    model_push(longint'(x));
    exp = model_out();
  endtask

  task automatic collect(input int stall, input bit poke, input int pa,
                         input logic signed [CW-1:0] pd,
                         output longint got, output int lat);
    int n = 0;
    m_ready = (stall == 0);
    if (poke) begin
      coef_wr_en   = 1'b1;
      coef_wr_addr = pa[AW-1:0];
      coef_wr_data = pd;
    end
    check1("busy_in_run", busy, 1'b1);
    check1("coef_wr_ready_in_run", coef_wr_ready, 1'b0);
    check1("s_ready_in_run", s_ready, 1'b0);
    while (!m_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    coef_wr_en = 1'b0;
    if (!m_valid) begin
      timeout("m_valid_wait");
      got     = 0;
      lat     = 0;
      m_ready = 1'b1;
      return;
    end
    lat = n + 1;
    got = longint'(m_data);
    for (int i = 0; i < stall; i++) begin
      s_valid = 1'b1;
      s_data  = DW'($urandom);
      @(posedge clk); #1;
      check1("hold_m_valid", m_valid, 1'b1);
      check("hold_m_data", longint'(m_data), got);
      check1("hold_s_ready", s_ready, 1'b0);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(posedge clk); #1;
    check1("post_hs_m_valid", m_valid, 1'b0);
    check1("post_hs_s_ready", s_ready, 1'b1);
  endtask

  task automatic do_sample(input logic signed [DW-1:0] x, input int stall,
                           input bit cw, input int ca, input logic signed [CW-1:0] cd,
                           input bit poke, input int pa, input logic signed [CW-1:0] pd,
                           output longint got);
    longint exp;
    int     lat;
    send(x, cw, ca, cd, exp);
    collect(stall, poke, pa, pd, got, lat);
    check("result_vs_model", got, exp);
    check("latency", longint'(lat), longint'(RUN_CYC + 1));
  endtask

  task automatic sample(input logic signed [DW-1:0] x, output longint got);
    do_sample(x, 0, 1'b0, 0, '0, 1'b0, 0, '0, got);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table for the impulse response
  // ---------------------------------------------------------------------------
  typedef struct {
    logic signed [DW-1:0] x;
    longint               exp;
  } vec_t;

  vec_t tbl [17];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint got;
    longint exp_v;
    int     prev;
    int     n;

    for (int i = 0; i < 17; i++) begin
      tbl[i].x = (i == 0) ? 16'sd1 : 16'sd0;
      if (i == 16)             tbl[i].exp = 0;
      else if (!SYM || i < 8)  tbl[i].exp = i + 1;
      else                     tbl[i].exp = 16 - i;
    end

    reset        = 1'b1;
    s_valid      = 1'b0;
    s_data       = '0;
    m_ready      = 1'b1;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check1("reset_m_valid", m_valid, 1'b0);
    check("reset_m_data", longint'(m_data), 0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_s_ready", s_ready, 1'b1);
    check1("reset_coef_wr_ready", coef_wr_ready, 1'b1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Impulse response with back-to-back samples
    for (int k = 0; k < TAPS; k++) write_coef(k, CW'(k + 1));
    prev = 0;
    for (int i = 0; i < 17; i++) begin
      sample(tbl[i].x, got);
      check("impulse", got, tbl[i].exp);
      if (i > 0) check("interval", longint'(acc_cyc - prev), longint'(RUN_CYC + 2));
      prev = acc_cyc;
    end

    // Extreme values: most negative coefficient and sample everywhere
    do_reset();
    for (int k = 0; k < TAPS; k++) write_coef(k, 16'sh8000);
    for (int i = 0; i < TAPS; i++) sample(16'sh8000, got);
    check("extreme_final", got, 64'sd1 << 34);

    // Backpressure, with junk s_valid presented while the result is held
    do_reset();
    write_coef(0, 16'sd3);
    write_coef(1, -16'sd2);
    do_sample(16'sd100, 10, 1'b0, 0, '0, 1'b0, 0, '0, got);
    check("backpressure_result", got, 300);
    sample(16'sd50, got);
    check("after_backpressure", got, -50);

    // Coefficient write while busy is ignored; in idle it takes effect
    do_reset();
    write_coef(0, 16'sd2);
    do_sample(16'sd1, 0, 1'b0, 0, '0, 1'b1, 0, 16'sh7FFF, got);
    check("wr_during_run_ignored", got, 2);
    write_coef(0, 16'sh7FFF);
    sample(16'sd1, got);
    check("wr_in_idle_applies", got, 32767);
    do_sample(16'sd1, 0, 1'b1, 1, 16'sd10, 1'b0, 0, '0, got);
    check("wr_with_accept_applies", got, 32777);

    // Reset in the middle of RUN clears history and coefficients
    do_reset();
    write_coef(0, 16'sd1);
    sample(16'sd7, got);
    send(16'sd9, 1'b0, 0, '0, exp_v);
    repeat (5) @(posedge clk);
    #1;
    check1("mid_run_busy", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1("async_rst_busy", busy, 1'b0);
    check1("async_rst_m_valid", m_valid, 1'b0);
    check1("async_rst_s_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check1("post_rst_s_ready", s_ready, 1'b1);
    check1("post_rst_m_valid", m_valid, 1'b0);
    write_coef(0, 16'sd3);
    write_coef(15, 16'sd5);
    sample(16'sd1, got);
    check("impulse_after_reset", got, 3);

    // Reset while a result is held drops m_valid at once
    send(16'sd4, 1'b0, 0, '0, exp_v);
    m_ready = 1'b0;
    n = 0;
    while (!m_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_valid) timeout("out_state_wait");
    else          check("held_before_reset", longint'(m_data), 12);
    #2;
    reset = 1'b1;
    #1;
    check1("rst_in_out_m_valid", m_valid, 1'b0);
    check("rst_in_out_m_data", longint'(m_data), 0);
    @(posedge clk); #1;
    reset   = 1'b0;
    m_ready = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      int                   nw;
      int                   st;
      bit                   cw;
      bit                   pk;
      int                   ca;
      int                   pa;
      logic signed [CW-1:0] cd;
      logic signed [CW-1:0] pd;
      logic signed [DW-1:0] x;
      nw = $urandom_range(0, 2);
      for (int w = 0; w < nw; w++) write_coef($urandom_range(0, TAPS - 1), CW'($urandom));
      case ($urandom_range(0, 7))
        0:       x = 16'sh8000;
        1:       x = 16'sh7FFF;
        default: x = DW'($urandom);
      endcase
      st = $urandom_range(0, 3);
      cw = ($urandom_range(0, 3) == 0);
      ca = $urandom_range(0, TAPS - 1);
      cd = CW'($urandom);
      pk = ($urandom_range(0, 2) == 0);
      pa = $urandom_range(0, TAPS - 1);
      pd = CW'($urandom);
      do_sample(x, st, cw, ca, cd, pk, pa, pd, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
